piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in, serial-out stage that feeds the 1101 Moore sequence detector's seq_in.
- Accepts DATA_W-bit words over a valid/ready handshake into a one-entry holding buffer.
- Shifts each word out one bit per shift_en strobe.
- Back-to-back words stream with no idle bit between them.
- Per-bit framing flags and a sent-word counter let downstream logic and benches align detector hits to word boundaries.

Parameters:
DATA_W, 8, word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.
IDLE_BIT, 0, value driven on ser_out while no word is being shifted.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
shift_en  input  1  bit strobe; advances one bit per cycle it is high; tie to 1 for one bit per clk
in_data  input  DATA_W  parallel word
in_valid  input  1  in_data valid
in_ready  output  1  holding buffer empty; a word is accepted when in_valid and in_ready are both high
ser_out  output  1  serial bit; connects to the detector's seq_in
ser_valid  output  1  ser_out carries a data bit
ser_first  output  1  current bit is the first bit of a word
ser_last  output  1  current bit is the last bit of a word
busy  output  1  shift register active or holding buffer full
words_sent  output  16  count of fully shifted words; wraps

Behaviour:
- Reset, asynchronous: state=IDLE, hold_full=0, bit_cnt=0, shreg=0, words_sent=0.
- Reset output values: in_ready=1, ser_valid=0, ser_first=0, ser_last=0, busy=0, ser_out=IDLE_BIT.
- State machine, 2 states:
  - IDLE: ser_valid=0 and shift_en is ignored. If hold_full at the clock edge: shreg<=hold, bit_cnt<=0, hold_full<=0, go to SHIFT.
  - SHIFT: ser_valid=1; ser_out = shreg[DATA_W-1-bit_cnt] if MSB_FIRST, else shreg[bit_cnt]. The bit is held until shift_en is high.
  - SHIFT, on shift_en with bit_cnt<DATA_W-1: bit_cnt<=bit_cnt+1.
  - SHIFT, on shift_en with bit_cnt==DATA_W-1: words_sent<=words_sent+1. If hold_full, reload shreg from hold, set bit_cnt<=0 and hold_full<=0, and stay in SHIFT (seamless). Otherwise go to IDLE.
- Handshake:
  - in_ready = !hold_full, combinational from the register.
  - On accept: hold<=in_data, hold_full<=1.
  - in_data is sampled only on accept. Holding in_valid with in_ready low is legal and loses nothing.
- Latency: word accepted at edge N -> first bit on ser_out with ser_valid=1 after edge N+1, provided the stage was IDLE.
- Flags are combinational from registers and are 0 outside SHIFT:
  - ser_first = SHIFT && bit_cnt==0.
  - ser_last = SHIFT && bit_cnt==DATA_W-1.
- busy = (state==SHIFT) || hold_full.
- Boundary cases:
  - Last-bit shift while hold_full and in_valid high: no accept that cycle (in_ready=0). in_ready rises the following cycle.
  - Throughput: sustained 1 word per DATA_W shift_en strobes, no bubble, when the source keeps hold filled.
  - shift_en low on the last bit: the word stays in SHIFT and words_sent does not increment.
  - words_sent wraps 16'hFFFF -> 0.
  - Reset mid-word: the partial word and the held word are discarded. Outputs return to reset values immediately, without waiting for clk.
- Exactly one bit leaves per shift_en in SHIFT. No bit is duplicated or dropped across a reload.

Decomposition:
- Shared package:
  - state encoding constants SER_IDLE=1'b0 and SER_SHIFT=1'b1.
  - default DATA_W.
  - WORDS_SENT_W=16.
- No sub-module is needed. Holding buffer, shifter, bit counter and FSM stay in one module of roughly 150 lines.

Test Plan:
- Single word: DATA_W=8, MSB_FIRST=1, shift_en=1, in_data=8'hD0 accepted at edge 0 -> ser_out 1,1,0,1,0,0,0,0 with ser_valid=1 from cycle 1 through 8. ser_first in cycle 1 only, ser_last in cycle 8 only. words_sent=1, then IDLE with ser_out=0.
- Back-to-back words: 8'hD0 then 8'h0D, in_valid held high -> 16 contiguous valid bits 11010000_00001101. No ser_valid gap. in_ready low from the second accept until the reload. words_sent=2.
- Paced output: shift_en high every 3rd cycle, word 8'hB5 -> each bit held exactly 3 cycles, ser_last low until the 8th bit, total 24 valid cycles.
- Backpressure: 3 words offered continuously while the first is shifting -> the third is accepted only in the cycle after the first word's last bit. No data loss; order preserved.
- Reset mid-word: reset asserted after 3 bits of 8'hFF with hold_full=1 -> ser_valid=0, in_ready=1, busy=0 and words_sent=0 immediately. The next word starts fresh at bit 0.
- LSB-first: MSB_FIRST=0, in_data=8'h0B -> ser_out 1,1,0,1,0,0,0,0, which drives the downstream 1101 detector to one hit.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared types and sizing helpers for the parallel-in, serial-out stage.
`timescale 1ns/1ps
package piso_serializer_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  localparam int DEFAULT_DATA_W = 8;
  localparam int WORDS_SENT_W   = 16;

  // Bit-index counter width; DATA_W is at least 2, so one bit is the floor.
  function automatic int cnt_width(input int data_w);
    return (data_w <= 2) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// One-entry holding buffer feeding a shifter; first bit appears one clk after accept when idle.
// in_ready drops while the buffer is full; a waiting word reloads on the last bit with no gap.
`timescale 1ns/1ps
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    shift_en,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    ser_out,
  output logic                    ser_valid,
  output logic                    ser_first,
  output logic                    ser_last,
  output logic                    busy,
  output logic [WORDS_SENT_W-1:0] words_sent
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  ser_state_t        state;
  logic [DATA_W-1:0] hold;
  logic              hold_full;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_idx;
  logic              shifting;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SER_IDLE;
      hold       <= '0;
      hold_full  <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      words_sent <= '0;
    end else begin
      // Accept only into an empty buffer, so it never collides with a reload below.
      if (in_valid && !hold_full) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end
      case (state)
        SER_IDLE: begin
          if (hold_full) begin
            shreg     <= hold;
            bit_cnt   <= '0;
            hold_full <= 1'b0;
            state     <= SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (shift_en) begin
            if (bit_cnt != LAST_CNT) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end else begin
              words_sent <= words_sent + WORDS_SENT_W'(1);
              if (hold_full) begin
                shreg     <= hold;
                bit_cnt   <= '0;
                hold_full <= 1'b0;
              end else begin
                state <= SER_IDLE;
              end
            end
          end
        end
        default: state <= SER_IDLE;
      endcase
    end
  end

  assign shifting  = (state == SER_SHIFT);
  assign bit_idx   = MSB_FIRST ? (LAST_CNT - bit_cnt) : bit_cnt;
  assign in_ready  = !hold_full;
  assign ser_valid = shifting;
  assign ser_out   = shifting ? shreg[bit_idx] : IDLE_BIT;
  assign ser_first = shifting && (bit_cnt == '0);
  assign ser_last  = shifting && (bit_cnt == LAST_CNT);
  assign busy      = shifting || hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: stream-level scoreboard for the MSB-first instance plus literal checks.
`timescale 1ns/1ps
module tb_piso_serializer;

  logic        clk;
  logic        reset;
  logic        shift_en;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        ser_out, ser_valid, ser_first, ser_last, busy;
  logic [15:0] words_sent;

  logic        l_shift_en;
  logic [7:0]  l_in_data;
  logic        l_in_valid;
  logic        l_in_ready;
  logic        l_ser_out, l_ser_valid, l_ser_first, l_ser_last, l_busy;
  logic [15:0] l_words_sent;

  int checks = 0;
  int errors = 0;

  piso_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_main (
    .clk(clk), .reset(reset), .shift_en(shift_en), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .ser_out(ser_out),
    .ser_valid(ser_valid), .ser_first(ser_first), .ser_last(ser_last),
    .busy(busy), .words_sent(words_sent)
  );

  piso_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .shift_en(l_shift_en), .in_data(l_in_data),
    .in_valid(l_in_valid), .in_ready(l_in_ready), .ser_out(l_ser_out),
    .ser_valid(l_ser_valid), .ser_first(l_ser_first), .ser_last(l_ser_last),
    .busy(l_busy), .words_sent(l_words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream model: accepted words queue up in order and leave one bit per strobe while ser_valid.
  logic [7:0]  wq[$];
  int          pos  = 0;
  logic [15:0] sent = 16'd0;
  logic [7:0]  mw;

  always @(negedge clk) begin
    if (reset) begin
      wq.delete();
      pos  = 0;
      sent = 16'd0;
    end else begin
      chk("m_words_sent", words_sent, sent);
      chk("m_busy", busy, wq.size() != 0);
      if (ser_valid) begin
        if (wq.size() == 0) begin
          chk("m_spurious_valid", ser_valid, 1'b0);
        end else begin
          mw = wq[0];
          chk("m_ser_out", ser_out, mw[7-pos]);
          chk("m_ser_first", ser_first, pos == 0);
          chk("m_ser_last", ser_last, pos == 7);
          if (shift_en) begin
            pos++;
            if (pos == 8) begin
              pos = 0;
              void'(wq.pop_front());
              sent = sent + 16'd1;
            end
          end
        end
      end else begin
        chk("m_idle_out", ser_out, 1'b0);
        chk("m_idle_flags", {ser_first, ser_last}, 2'b00);
      end
      if (in_valid && in_ready) wq.push_back(in_data);
    end
  end

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    shift_en = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_outs", {ser_valid, ser_first, ser_last, busy, ser_out}, 5'b0);
    chk("rst_words_sent", words_sent, 16'd0);
    step();
    reset = 1'b0;
    step();
  endtask

  logic [7:0]  v8;
  logic [15:0] v16;
  logic [7:0]  w4[3];
  int          acc_edge[3];
  int          idx;
  logic        acc;
  logic [3:0]  hist;
  int          hits;

  initial begin
    reset = 1'b1; shift_en = 1'b1; in_data = '0; in_valid = 1'b0;
    l_shift_en = 1'b1; l_in_data = '0; l_in_valid = 1'b0;
    do_reset();

    // Single word, MSB first
    v8 = 8'hD0;
    in_valid = 1'b1; in_data = 8'hD0;
    step();
    in_valid = 1'b0;
    chk("t1_ready_after_accept", in_ready, 1'b0);
    chk("t1_no_valid_yet", ser_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t1_valid", ser_valid, 1'b1);
      chk("t1_bit", ser_out, v8[7-i]);
      chk("t1_first", ser_first, i == 0);
      chk("t1_last", ser_last, i == 7);
    end
    step();
    chk("t1_idle_valid", ser_valid, 1'b0);
    chk("t1_idle_out", ser_out, 1'b0);
    chk("t1_words_sent", words_sent, 16'd1);

    // Back-to-back words with in_valid held high
    do_reset();
    v16 = 16'b11010000_00001101;
    in_valid = 1'b1; in_data = 8'hD0;
    step();
    in_data = 8'h0D;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 1) in_valid = 1'b0;
      chk("t2_valid", ser_valid, 1'b1);
      chk("t2_bit", ser_out, v16[15-i]);
      chk("t2_first", ser_first, (i % 8) == 0);
      chk("t2_last", ser_last, (i % 8) == 7);
      chk("t2_ready", in_ready, (i == 0) || (i >= 8));
    end
    step();
    chk("t2_idle_valid", ser_valid, 1'b0);
    chk("t2_words_sent", words_sent, 16'd2);

    // Paced output: one strobe every third cycle
    do_reset();
    v8 = 8'hB5;
    shift_en = 1'b0;
    in_valid = 1'b1; in_data = 8'hB5;
    step();
    in_valid = 1'b0;
    step();
    for (int c = 0; c < 24; c++) begin
      chk("t3_valid", ser_valid, 1'b1);
      chk("t3_bit", ser_out, v8[7-c/3]);
      chk("t3_first", ser_first, (c / 3) == 0);
      chk("t3_last", ser_last, (c / 3) == 7);
      chk("t3_words_held", words_sent, 16'd0);
      shift_en = ((c % 3) == 2);
      step();
    end
    chk("t3_idle_valid", ser_valid, 1'b0);
    chk("t3_words_sent", words_sent, 16'd1);
    shift_en = 1'b1;

    // Backpressure: three words offered continuously
    do_reset();
    w4[0] = 8'hA1; w4[1] = 8'h5A; w4[2] = 8'hC3;
    idx = 0;
    in_valid = 1'b1; in_data = w4[0];
    for (int t = 0; t < 31; t++) begin
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        acc_edge[idx] = t;
        idx++;
        if (idx < 3) in_data = w4[idx];
        else in_valid = 1'b0;
      end
      if (t == 8) chk("t4_ready_last_bit", in_ready, 1'b0);
      if (t == 9) chk("t4_ready_after_reload", in_ready, 1'b1);
    end
    chk("t4_accepts", idx, 3);
    chk("t4_acc0", acc_edge[0], 0);
    chk("t4_acc1", acc_edge[1], 2);
    chk("t4_acc2", acc_edge[2], 10);
    chk("t4_words_sent", words_sent, 16'd3);
    chk("t4_drained", wq.size(), 0);

    // Reset mid-word with a word held
    in_valid = 1'b1; in_data = 8'hFF;
    step();
    in_data = 8'h3C;
    step();
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("t5_busy_before", busy, 1'b1);
    chk("t5_ready_before", in_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", ser_valid, 1'b0);
    chk("t5_rst_ready", in_ready, 1'b1);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_words", words_sent, 16'd0);
    step();
    reset = 1'b0;
    v8 = 8'h96;
    in_valid = 1'b1; in_data = 8'h96;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t5_bit", ser_out, v8[7-i]);
      chk("t5_first", ser_first, i == 0);
    end
    step();
    chk("t5_words_sent", words_sent, 16'd1);
    chk("t5_drained", wq.size(), 0);

    // LSB-first instance into a 1101 detector
    v8 = 8'b11010000;
    hist = 4'b0; hits = 0;
    l_in_valid = 1'b1; l_in_data = 8'h0B;
    step();
    l_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t6_valid", l_ser_valid, 1'b1);
      chk("t6_bit", l_ser_out, v8[7-i]);
      chk("t6_last", l_ser_last, i == 7);
      hist = {hist[2:0], l_ser_out};
      if (hist == 4'b1101) hits++;
    end
    step();
    chk("t6_idle_valid", l_ser_valid, 1'b0);
    chk("t6_words_sent", l_words_sent, 16'd1);
    chk("t6_hits", hits, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
